// File: rtl/fade_sequencer.sv
// fade_sequencer: ramps a registered brightness level one LSB at a time
// toward a commanded target. A free-running prescaler sets the base tick,
// cmd_step scales it into the step interval, and steps are only applied on
// PWM period boundaries so the downstream duty never changes mid-period.
module fade_sequencer #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [3:0]       cmd_step,
    input  logic             period_start,
    output logic [WIDTH-1:0] level,
    output logic             busy,
    output logic             done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic             tick;
    logic [WIDTH-1:0] target_r;
    logic [3:0]       step_r;
    logic [3:0]       step_cnt;
    logic             pending;
    logic [WIDTH-1:0] next_level;

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign cmd_ready  = (state == IDLE) && !rst;
    // level never crosses target_r, so the +/-1 can never wrap
    assign next_level = (level < target_r) ? level + 1'b1 : level - 1'b1;

    // Free-running base-tick prescaler; phase is independent of commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Command handshake, step-interval counting and period-gated level update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            level    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            target_r <= '0;
            step_r   <= '0;
            step_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        target_r <= cmd_target;
                        step_r   <= cmd_step;
                        step_cnt <= '0;
                        pending  <= 1'b0;
                        if (cmd_target == level) begin
                            done <= 1'b1;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    // Apply uses the pending value from before this edge; a
                    // freshly elapsed interval below overrides the clear so it
                    // is not lost.
                    if (period_start && pending) begin
                        level   <= next_level;
                        pending <= 1'b0;
                        if (next_level == target_r) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    if (tick) begin
                        if (step_cnt == step_r) begin
                            step_cnt <= '0;
                            pending  <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer with a small prescaler; a behavioural model
// counts absolute cycles and ticks to predict level/busy/done/cmd_ready.
module tb_fade_sequencer;

    localparam int W  = 8;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_target;
    logic [3:0]   cmd_step;
    logic         period_start;
    logic [W-1:0] level;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    int ps_mode = 0;
    int ps_cnt  = 0;
    logic last_ps = 1'b0;

    // model state
    logic [W-1:0] m_level, m_tgt;
    bit m_busy, m_done, m_pend;
    int m_step, m_ticks, m_cyc;

    fade_sequencer #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .period_start(period_start),
        .level(level), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: a tick happens when the absolute cycle count since reset
    // release hits TD-1 mod TD; a step is due every (step+1)-th tick of the ramp.
    always @(posedge clk) begin : model
        bit tick, due, apply;
        if (rst) begin
            m_level = '0; m_tgt = '0; m_busy = 0; m_done = 0; m_pend = 0;
            m_step = 0; m_ticks = 0; m_cyc = 0;
        end else begin
            tick = (m_cyc % TD) == TD - 1;
            m_done = 0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_tgt = cmd_target; m_step = int'(cmd_step); m_ticks = 0; m_pend = 0;
                    if (cmd_target == m_level) m_done = 1;
                    else m_busy = 1;
                end
            end else begin
                apply = period_start && m_pend;
                due = 0;
                if (tick) begin
                    m_ticks++;
                    due = (m_ticks % (m_step + 1)) == 0;
                end
                if (apply) begin
                    m_level = (m_level < m_tgt) ? m_level + 1'b1 : m_level - 1'b1;
                    if (m_level == m_tgt) begin m_busy = 0; m_done = 1; end
                end
                m_pend = due ? 1'b1 : (apply ? 1'b0 : m_pend);
            end
            m_cyc++;
        end
    end

    function automatic logic [W+2:0] exp_vec();
        return {m_level, m_busy, m_done, (!m_busy && !rst)};
    endfunction

    task automatic cyc();
        @(negedge clk);
        last_ps = period_start;
        ps_cnt++;
        case (ps_mode)
            0: period_start = 1'b1;
            1: period_start = (ps_cnt % 16 == 0);
            default: period_start = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic issue(input logic [W-1:0] tgt, input logic [3:0] stp);
        cmd_valid = 1'b1; cmd_target = tgt; cmd_step = stp;
        cyc();
        cmd_valid = 1'b0; cmd_target = W'($urandom); cmd_step = 4'($urandom);
    endtask

    task automatic ramp_to(input logic [W-1:0] tgt);
        int t = 0;
        issue(tgt, 4'd0);
        while (m_busy && t < 3000) begin cyc(); t++; end
        if (t >= 3000) begin
            n_fail++; n_checks++;
            $display("FAIL preload_timeout: level=%0d target=%0d", level, tgt);
        end
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'($urandom); cmd_target = W'($urandom); cmd_step = 4'($urandom);
            cyc();
            n_checks++;
            if ({level, busy, done, cmd_ready} !== {8'd0, 3'b000}) begin
                n_fail++;
                $display("FAIL reset_hold: got lvl=%0d b=%0b d=%0b r=%0b exp 0 0 0 0", level, busy, done, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        rst = 1'b0;
        cyc();
        n_checks++;
        if ({level, busy, done, cmd_ready} !== {8'd0, 3'b001}) begin
            n_fail++;
            $display("FAIL reset_release: got lvl=%0d b=%0b d=%0b r=%0b exp 0 0 0 1", level, busy, done, cmd_ready);
        end
    endtask

    task automatic test_ramp_up();
        int chg[$];
        int t = 0;
        logic [W-1:0] prev;
        ps_mode = 0;
        issue(8'd3, 4'd0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy: got %0b exp 1", busy); end
        prev = level;
        while (m_busy && t < 200) begin
            cyc(); t++;
            n_checks++;
            if ({level, busy, done, cmd_ready} !== exp_vec()) begin
                n_fail++; $display("FAIL up_model: got %h exp %h", {level, busy, done, cmd_ready}, exp_vec());
            end
            if (level !== prev) begin
                chg.push_back(t);
                n_checks++;
                if (level == 8'd3 && {busy, done} !== 2'b01) begin
                    n_fail++; $display("FAIL up_arrive: got busy=%0b done=%0b exp 0 1", busy, done);
                end
            end
            prev = level;
        end
        n_checks++;
        if (chg.size() != 3 || chg[1] - chg[0] != 4 || chg[2] - chg[1] != 4) begin
            n_fail++; $display("FAIL up_spacing: got %0d changes, exp 3 spaced 4", chg.size());
        end
        cyc();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL up_done_width: got %0b exp 0", done); end
    endtask

    task automatic test_period_gating();
        int chg = 0;
        int t = 0;
        logic [W-1:0] prev;
        rst = 1'b1; cyc(); rst = 1'b0;
        ps_mode = 1; ps_cnt = 0;
        issue(8'd2, 4'd0);
        prev = level;
        while (m_busy && t < 300) begin
            cyc(); t++;
            n_checks++;
            if ({level, busy, done, cmd_ready} !== exp_vec()) begin
                n_fail++; $display("FAIL gate_model: got %h exp %h", {level, busy, done, cmd_ready}, exp_vec());
            end
            if (level !== prev) begin
                chg++;
                n_checks++;
                if (last_ps !== 1'b1 || level !== W'(chg)) begin
                    n_fail++; $display("FAIL gate_step: got lvl=%0d ps=%0b exp lvl=%0d ps=1", level, last_ps, chg);
                end
            end
            prev = level;
        end
        n_checks++;
        if (chg != 2 || level !== 8'd2) begin
            n_fail++; $display("FAIL gate_count: got %0d changes lvl=%0d exp 2 lvl=2", chg, level);
        end
    endtask

    task automatic test_ramp_down();
        int chg[$];
        int t = 0;
        logic [W-1:0] prev;
        ps_mode = 0;
        ramp_to(8'd3);
        issue(8'd0, 4'd1);
        prev = level;
        while (m_busy && t < 300) begin
            cyc(); t++;
            n_checks++;
            if ({level, busy, done, cmd_ready} !== exp_vec()) begin
                n_fail++; $display("FAIL down_model: got %h exp %h", {level, busy, done, cmd_ready}, exp_vec());
            end
            if (level !== prev) chg.push_back(t);
            prev = level;
        end
        n_checks++;
        if (chg.size() != 3 || chg[1] - chg[0] != 8 || chg[2] - chg[1] != 8 || done !== 1'b1 || level !== 8'd0) begin
            n_fail++; $display("FAIL down_spacing: got %0d changes lvl=%0d done=%0b exp 3 spaced 8 lvl=0 done=1", chg.size(), level, done);
        end
    endtask

    task automatic test_zero_distance();
        ps_mode = 0;
        ramp_to(8'd5);
        issue(8'd5, 4'($urandom));
        n_checks++;
        if ({level, busy, done, cmd_ready} !== {8'd5, 3'b011}) begin
            n_fail++; $display("FAIL zero_done: got lvl=%0d b=%0b d=%0b r=%0b exp 5 0 1 1", level, busy, done, cmd_ready);
        end
        cyc();
        n_checks++;
        if ({level, busy, done, cmd_ready} !== {8'd5, 3'b001}) begin
            n_fail++; $display("FAIL zero_after: got lvl=%0d b=%0b d=%0b r=%0b exp 5 0 0 1", level, busy, done, cmd_ready);
        end
    endtask

    task automatic test_busy_abort();
        int t = 0;
        ps_mode = 0;
        issue(8'd50, 4'd0);
        for (int i = 0; i < 24; i++) begin
            if (i >= 8) begin cmd_valid = 1'b1; cmd_target = 8'd200; cmd_step = 4'd0; end
            cyc();
            n_checks++;
            if ({level, busy, done, cmd_ready} !== exp_vec() || cmd_ready !== 1'b0 || level > 8'd50) begin
                n_fail++; $display("FAIL busy_ignore: got %h exp %h", {level, busy, done, cmd_ready}, exp_vec());
            end
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        cyc();
        n_checks++;
        if ({level, busy, done} !== {8'd0, 2'b00}) begin
            n_fail++; $display("FAIL abort: got lvl=%0d b=%0b d=%0b exp 0 0 0", level, busy, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if ({level, busy, done, cmd_ready} !== {8'd0, 3'b001}) begin
                n_fail++; $display("FAIL abort_idle: got lvl=%0d b=%0b d=%0b r=%0b exp 0 0 0 1", level, busy, done, cmd_ready);
            end
        end
        issue(8'd4, 4'd0);
        while (m_busy && t < 300) begin
            cyc(); t++;
            n_checks++;
            if ({level, busy, done, cmd_ready} !== exp_vec()) begin
                n_fail++; $display("FAIL after_abort: got %h exp %h", {level, busy, done, cmd_ready}, exp_vec());
            end
        end
        n_checks++;
        if (level !== 8'd4 || done !== 1'b1 || t >= 300) begin
            n_fail++; $display("FAIL after_abort_arrive: got lvl=%0d done=%0b exp 4 1", level, done);
        end
    endtask

    task automatic test_random();
        ps_mode = 2;
        for (int k = 0; k < 8; k++) begin
            int tg, t;
            tg = int'(level) + $urandom_range(0, 16) - 8;
            if (tg < 0) tg = 0;
            if (tg > 255) tg = 255;
            issue(W'(tg), 4'($urandom_range(0, 3)));
            t = 0;
            while (t < 3000) begin
                n_checks++;
                if ({level, busy, done, cmd_ready} !== exp_vec()) begin
                    n_fail++; $display("FAIL rand_model: got %h exp %h", {level, busy, done, cmd_ready}, exp_vec());
                end
                if (!m_busy) break;
                cyc(); t++;
            end
            if (t >= 3000) begin
                n_checks++; n_fail++;
                $display("FAIL rand_timeout: got lvl=%0d exp %0d", level, tg);
            end
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0; period_start = 1'b0;
        test_reset();
        test_ramp_up();
        test_period_gating();
        test_ramp_down();
        test_zero_distance();
        test_busy_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
